// File: rtl/core_pkg.sv
// core_pkg: shared types and width defaults for the program-counter sequencer.
package core_pkg;
    localparam int PC_W_DEF  = 12;
    localparam int OFF_W_DEF = 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    typedef enum logic [2:0] {NPC_SEQ, NPC_BR, NPC_RET, NPC_HOLD, NPC_START} npc_sel_e;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top_idx;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign top_idx = ptr_q - 1'b1;
    assign top     = mem_q[top_idx];

    // ptr_q is the next write slot; wrapping it is what discards the oldest entry
    always_comb begin
        ptr_d = clear ? '0 : push ? ptr_q + 1'b1 : (pop && !empty) ? ptr_q - 1'b1 : ptr_q;
        cnt_d = clear ? '0 : push ? (full ? cnt_q : cnt_q + 1'b1) : (pop && !empty) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem_q[ptr_q] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with start/run/done control, stall, halt and call/return stack.
module pc_sequencer import core_pkg::*; #(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              OFF_W      = OFF_W_DEF,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_take,
    input  logic             call,
    input  logic             ret,
    input  logic [OFF_W-1:0] branch_off,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             done,
    output logic             ras_overflow,
    output logic             ras_underflow
);
    localparam int EW = PC_W > OFF_W ? PC_W : OFF_W;

    state_e          state_q, state_d;
    npc_sel_e        sel;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_br, ras_top;
    logic [EW-1:0]   off_ext;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            live, push, pop, ras_empty, ras_full;

    // live: a non-stalled RUN cycle where the decoded controls actually take effect
    assign live    = state_q == S_RUN && !stall && !start;
    assign push    = live && !halt && !ret && call;
    assign pop     = live && !halt && ret && !ras_empty;
    assign off_ext = EW'($signed(branch_off));
    assign pc_inc  = pc_q + 1'b1;
    assign pc_br   = pc_inc + off_ext[PC_W-1:0];

    ras_stack #(.WIDTH(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = start ? S_RUN : (live && halt) ? S_DONE : state_q;
        sel     = start ? NPC_START : (!live || halt) ? NPC_HOLD :
                  ret ? (ras_empty ? NPC_SEQ : NPC_RET) :
                  (call || branch_take) ? NPC_BR : NPC_SEQ;
        ovf_d   = !start && (ovf_q || (push && ras_full));
        unf_d   = !start && (unf_q || (live && !halt && ret && ras_empty));
        case (sel)
            NPC_SEQ:   pc_d = pc_inc;
            NPC_BR:    pc_d = pc_br;
            NPC_RET:   pc_d = ras_top;
            NPC_START: pc_d = START_ADDR;
            default:   pc_d = pc_q;
        endcase
    end

    always_comb begin
        pc_valid      = state_q == S_RUN && !stall;
        done          = state_q == S_DONE;
        pc            = pc_q;
        ras_overflow  = ovf_q;
        ras_underflow = unf_q;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed stimulus checked against a queue-based reference model.
module tb_pc_sequencer;
    localparam int D = 4;
    localparam int MASK = 'hFFF;
    localparam logic [6:0] R = 7'b1000000, S = 7'b0100000, ST = 7'b0010000, HA = 7'b0001000,
                           BR = 7'b0000100, CA = 7'b0000010, RT = 7'b0000001;

    logic        clk = 0, reset = 0, start = 0, stall = 0, halt = 0, branch_take = 0, call = 0, ret = 0;
    logic [7:0]  branch_off = '0;
    logic [11:0] pc;
    logic        pc_valid, done, ras_overflow, ras_underflow;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
        .branch_take(branch_take), .call(call), .ret(ret), .branch_off(branch_off),
        .pc(pc), .pc_valid(pc_valid), .done(done),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [15:0] exp_q[$];

    int m_st = 0, m_pc = 0, m_ovf = 0, m_unf = 0, m_known = 0;
    int ras[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", n, a, e);
    endtask

    // Reference: the RAS is a plain list, the oldest entry is dropped once it holds more than D
    task automatic step(input logic [6:0] f, input logic [7:0] o);
        int so, nx;
        {reset, start, stall, halt, branch_take, call, ret} = f;
        branch_off = o;
        if (m_known != 0)
            exp_q.push_back({12'(m_pc), m_st == 1 && !stall, m_st == 2, 1'(m_ovf), 1'(m_unf)});
        so = int'(o) - (o[7] ? 256 : 0);
        nx = (m_pc + 1) & MASK;
        if (reset) begin
            m_st = 0; m_pc = 0; ras.delete(); m_ovf = 0; m_unf = 0; m_known = 1;
        end else if (m_known == 0) begin
        end else if (start) begin
            m_st = 1; m_pc = 0; ras.delete(); m_ovf = 0; m_unf = 0;
        end else if (m_st == 1 && !stall) begin
            if (halt) m_st = 2;
            else if (ret) begin
                if (ras.size() > 0) m_pc = ras.pop_back();
                else begin m_pc = nx; m_unf = 1; end
            end else if (call) begin
                ras.push_back(nx);
                if (ras.size() > D) begin void'(ras.pop_front()); m_ovf = 1; end
                m_pc = (nx + so) & MASK;
            end else if (branch_take) m_pc = (nx + so) & MASK;
            else m_pc = nx;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e, a;
            e = exp_q.pop_front();
            a = {pc, pc_valid, done, ras_overflow, ras_underflow};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL scoreboard t=%0t: got pc=%h v/d/o/u=%b want pc=%h v/d/o/u=%b",
                          $time, a[15:4], a[3:0], e[15:4], e[3:0]);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(R, 0); step(R, 0);
        chk("reset_pc", pc, 12'h000); chk("reset_valid", pc_valid, 1'b0);
        step(S, 0);
        chk("start_pc", pc, 12'h000); chk("start_valid", pc_valid, 1'b1);
        repeat (3) step(0, 0);
        chk("seq_pc", pc, 12'h003);
        step(BR, 8'h0C); chk("br_fwd", pc, 12'h010);
        step(BR, 8'hFC); chk("br_neg", pc, 12'h00D);
        step(ST, 0); step(ST, 0);
        chk("stall_pc", pc, 12'h00D); chk("stall_valid", pc_valid, 1'b0);
        step(BR, 8'h12); chk("to_20", pc, 12'h020);
        step(CA, 8'h05); chk("call1", pc, 12'h026);
        step(CA, 8'h10); chk("call2", pc, 12'h037);
        step(RT, 0); chk("ret1", pc, 12'h027);
        step(RT, 0); chk("ret2", pc, 12'h021);
        repeat (5) step(CA, 0);
        chk("ovf", ras_overflow, 1'b1);
        step(RT, 0); chk("ovf_ret1", pc, 12'h026);
        repeat (3) step(RT, 0);
        chk("ovf_ret4", pc, 12'h023); chk("unf_clear", ras_underflow, 1'b0);
        step(RT, 0); chk("unf_pc", pc, 12'h024); chk("unf", ras_underflow, 1'b1);
        step(BR, 8'h1F); chk("to_44", pc, 12'h044);
        step(HA | BR, 8'h10);
        repeat (10) step(0, 0);
        chk("halt_pc", pc, 12'h044); chk("halt_done", done, 1'b1);
        step(S, 0);
        chk("restart_pc", pc, 12'h000); chk("restart_done", done, 1'b0);
        chk("restart_flags", {ras_overflow, ras_underflow}, 2'b00);
        step(BR, 8'hFE); chk("to_fff", pc, 12'hFFF);
        step(0, 0); chk("wrap", pc, 12'h000);
        step(CA, 8'h05); chk("call_pre", pc, 12'h006);
        step(CA | RT, 8'h30); chk("call_ret", pc, 12'h001);
        step(R, 0); chk("mid_reset_pc", pc, 12'h000); chk("mid_reset_valid", pc_valid, 1'b0);
        step(BR | CA, 8'h33); chk("idle_ignore", pc, 12'h000);
        step(S, 0);
        for (int i = 0; i < 600; i++) begin
            logic [6:0] f;
            f[6] = $urandom_range(79) == 0;
            f[5] = $urandom_range(39) == 0;
            f[4] = $urandom_range(4) == 0;
            f[3] = $urandom_range(24) == 0;
            f[2] = $urandom_range(2) == 0;
            f[1] = $urandom_range(3) == 0;
            f[0] = $urandom_range(3) == 0;
            step(f, 8'($urandom));
        end
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter and sequencing unit for the next-generation core. It replaces the fixed 12-bit PC, PC+1 adder and branch-offset adder with one block. The block adds what the current datapath lacks: a start/run/done state machine, pipeline stall, halt, and a call/return address stack (RAS). It sits between the controller (`start`, `halt`, branch/call/ret decode, `stall`) and instruction memory (`pc`).

Parameters:
PC_W, 12, PC and instruction-address width.
OFF_W, 8, width of the signed branch/call offset from the ALU.
RAS_DEPTH, 4, return-address stack entries; must be a power of two and at least 2.
START_ADDR, 0, PC value loaded on reset and on start.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
start  in  1  begins (or restarts) a program.
stall  in  1  holds PC and RAS for this cycle.
halt  in  1  ends the program; decoded from the current instruction.
branch_take  in  1  taken branch/jump this cycle.
call  in  1  call: push return address, then jump.
ret  in  1  return: pop RAS into PC.
branch_off  in  OFF_W  signed offset relative to PC+1.
pc  out  PC_W  registered current instruction address.
pc_valid  out  1  pc holds a live instruction this cycle.
done  out  1  program finished; held high.
ras_overflow  out  1  sticky flag: push while full.
ras_underflow  out  1  sticky flag: pop while empty.

Behaviour:
- One clock. Reset is synchronous and active-high, named `reset`; clock named `clk`.
- Reset values:
  - state=IDLE, pc=START_ADDR, pc_valid=0, done=0.
  - RAS count=0; both sticky flags=0.
  - Reset asserted mid-program has the same effect on the next edge.
- States:
  - IDLE, waiting for start.
  - RUN, fetching instructions.
  - DONE, program finished.
- pc_valid = (state==RUN) && !stall. It is combinational from state and stall.
- IDLE:
  - start=1 -> RUN; pc=START_ADDR; RAS cleared; done=0.
  - All other inputs are ignored.
- RUN, start=1: restart. pc=START_ADDR, RAS emptied, flags cleared, stay in RUN. Start overrides every other input.
- RUN, stall=1: pc, RAS and state all hold. halt, branch, call and ret are ignored.
- RUN, not stalled, next-PC priority (highest first):
  1. halt -> DONE; pc holds; done=1 from the next cycle.
  2. ret, RAS non-empty -> pc=top entry; pop.
  3. ret, RAS empty -> pc=PC+1; ras_underflow set.
  4. call -> push PC+1; pc=PC+1+sext(branch_off).
  5. branch_take -> pc=PC+1+sext(branch_off).
  6. otherwise -> pc=PC+1.
- call and ret asserted together: ret wins and call is ignored. branch_take is ignored whenever call or ret is asserted.
- Arithmetic:
  - branch_off is sign-extended to PC_W.
  - All sums are modulo 2^PC_W, so the PC wraps silently (e.g. PC=0xFFF, +1 -> 0x000).
  - If OFF_W > PC_W, keep the low PC_W bits.
- RAS is circular:
  - A push when count==RAS_DEPTH overwrites the oldest entry; count stays at RAS_DEPTH; ras_overflow is set.
  - A pop after such an overwrite returns the surviving entries in LIFO order.
- DONE:
  - done stays 1; pc holds.
  - start=1 -> RUN as from IDLE, and done returns to 0 on the same edge.
- Sticky flags clear only on reset or start.

Decomposition:
- A shared package `core_pkg` holds:
  - the state enum (S_IDLE, S_RUN, S_DONE);
  - the next-PC select enum (NPC_SEQ, NPC_BR, NPC_RET, NPC_HOLD, NPC_START);
  - localparam defaults PC_W=12, OFF_W=8.
- One sub-module is natural: `ras_stack`.
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, push_data, top, empty, full, clear.
  - Internally a circular pointer plus a saturating count.

Test Plan:
1. Reset, then start pulse. Expect pc=0x000 and pc_valid=1. Run 3 idle cycles; expect pc sequence 0,1,2,3.
2. At pc=0x010, assert branch_take with branch_off=0xFC (−4). Expect next pc=0x00D. Then at pc=0x00D, assert stall for 2 cycles: pc stays 0x00D and pc_valid=0.
3. At pc=0x020, call with off=0x05: expect pc=0x026. At 0x026, call with off=0x10: expect pc=0x037. Then ret gives 0x027, and ret again gives 0x021.
4. Issue 5 calls with RAS_DEPTH=4: ras_overflow=1. Then 4 rets return the latest 4 return addresses in order. A 5th ret gives pc+1 and sets ras_underflow=1.
5. Assert halt at pc=0x044 together with branch_take. Expect state DONE, pc=0x044, done=1 held for 10 cycles. Then start: pc=0x000, done=0, both flags=0.
6. Wrap and corner cases:
   - pc=0xFFF with no control -> pc=0x000.
   - call and ret asserted together -> acts as ret only.
   - reset mid-RUN -> IDLE, pc=0x000, pc_valid=0.
